// File: rtl/alu_seq_if.sv
// Types and handshake interface for the registered sequential ALU (alu_seq).
// The package sits ahead of the interface so both the interface and the design can import it.

package alu_seq_pkg;

    // Opcode set of the combinational ALU, extended with SUB, LSR and MUL.
    // Encodings 11..15 are undefined and produce result 0 with only Z set.
    typedef enum logic [3:0] {
        ALU_OP_ADD = 4'd0,
        ALU_OP_OR  = 4'd1,
        ALU_OP_AND = 4'd2,
        ALU_OP_XOR = 4'd3,
        ALU_OP_NOT = 4'd4,
        ALU_OP_NEG = 4'd5,
        ALU_OP_LSL = 4'd6,
        ALU_OP_ASR = 4'd7,
        ALU_OP_SUB = 4'd8,
        ALU_OP_LSR = 4'd9,
        ALU_OP_MUL = 4'd10
    } alu_operation_e;

    // Sequencer state, exported on the debug port of alu_seq.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } alu_seq_state_e;

endpackage

// Handshake: a transfer happens on a rising edge where valid and ready are both high.
// A producer holds valid and its payload stable until that edge; ready may depend
// combinationally on the other side's state but never on the same side's valid.
interface alu_seq_if #(
    parameter int Width = 8
);
    import alu_seq_pkg::*;

    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [Width-1:0]     a_i;
    logic [Width-1:0]     b_i;
    alu_operation_e       op_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [Width-1:0]     result_o;
    logic [3:0]           flags_o;

    modport master (
        output in_valid_i, a_i, b_i, op_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, flags_o
    );

    modport slave (
        input  in_valid_i, a_i, b_i, op_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, flags_o
    );

endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with {N,Z,C,V} flags.
// Single-cycle ops complete with latency 1; MUL is a shift-add over Width cycles.
// Build option: define ALU_SEQ_MUL_EN to compile in the multiplier, BUSY state and
// step counter. Without it MUL behaves as an undefined opcode (result 0, Z=1, latency 1).

module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int Width = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    alu_seq_if.slave        bus,
    output alu_seq_state_e  state_o
);

    localparam int Msb = Width - 1;

    alu_seq_state_e   state_q;
    logic             out_valid_q;
    logic [Width-1:0] result_q;
    logic [3:0]       flags_q;
    logic             accept;
    logic             is_mul;

    // A new op may enter only when idle and the output slot is free or being emptied.
    assign bus.in_ready_o  = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready_i);
    assign accept          = bus.in_valid_i && bus.in_ready_o;
    assign bus.out_valid_o = out_valid_q;
    assign bus.result_o    = result_q;
    assign bus.flags_o     = flags_q;
    assign state_o         = state_q;

    // Shared adder: ADD is x+y, SUB is a+~b+1, NEG is 0+~a+1.
    logic [Width-1:0] add_x;
    logic [Width-1:0] add_y;
    logic             add_cin;
    logic [Width:0]   add_sum;
    logic             add_v;

    // Select adder operands for ADD/SUB/NEG.
    always_comb begin
        add_x   = bus.a_i;
        add_y   = bus.b_i;
        add_cin = 1'b0;
        case (bus.op_i)
            ALU_OP_SUB: begin
                add_y   = ~bus.b_i;
                add_cin = 1'b1;
            end
            ALU_OP_NEG: begin
                add_x   = '0;
                add_y   = ~bus.a_i;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{Width{1'b0}}, add_cin};
    // Signed overflow: both addends share a sign that the sum does not.
    assign add_v   = (add_x[Msb] == add_y[Msb]) && (add_sum[Msb] != add_x[Msb]);

    logic [Width-1:0] res_c;
    logic             c_c;
    logic             v_c;
    logic [3:0]       flags_c;

    // Single-cycle result and C/V. Shifts by >= Width fall out of SV shift semantics
    // (zero fill, or sign fill for the arithmetic shift).
    always_comb begin
        res_c = '0;
        c_c   = 1'b0;
        v_c   = 1'b0;
        case (bus.op_i)
            ALU_OP_ADD, ALU_OP_SUB, ALU_OP_NEG: begin
                res_c = add_sum[Msb:0];
                c_c   = add_sum[Width];
                v_c   = add_v;
            end
            ALU_OP_OR:  res_c = bus.a_i | bus.b_i;
            ALU_OP_AND: res_c = bus.a_i & bus.b_i;
            ALU_OP_XOR: res_c = bus.a_i ^ bus.b_i;
            ALU_OP_NOT: res_c = ~bus.a_i;
            ALU_OP_LSL: res_c = bus.a_i << bus.b_i;
            ALU_OP_LSR: res_c = bus.a_i >> bus.b_i;
            ALU_OP_ASR: res_c = $unsigned($signed(bus.a_i) >>> bus.b_i);
            default:    res_c = '0;
        endcase
    end

    assign flags_c = {res_c[Msb], (res_c == '0), c_c, v_c};

`ifdef ALU_SEQ_MUL_EN
    localparam int CntW = $clog2(Width);

    // Product register: high half accumulates, low half holds the remaining multiplier bits.
    logic [2*Width-1:0] prod_q;
    logic [2*Width-1:0] prod_first;
    logic [2*Width-1:0] prod_next;
    logic [Width-1:0]   mcand_q;
    logic [CntW-1:0]    cnt_q;

    // One shift-add step: conditionally add the multiplicand to the high half, shift right.
    function automatic logic [2*Width-1:0] mul_step(input logic [2*Width-1:0] p,
                                                     input logic [Width-1:0]   m);
        logic [Width:0] upper;
        upper = {1'b0, p[2*Width-1:Width]} + (p[0] ? {1'b0, m} : {(Width+1){1'b0}});
        return {upper, p[Width-1:1]};
    endfunction

    // The accept edge already performs the first step, so Width steps end Width-1 edges later.
    assign prod_first = mul_step({{Width{1'b0}}, bus.b_i}, bus.a_i);
    assign prod_next  = mul_step(prod_q, mcand_q);
    assign is_mul     = (bus.op_i == ALU_OP_MUL);
`else
    assign is_mul     = 1'b0;
`endif

    // Sequencer and output register: IDLE issues single-cycle ops, BUSY runs the multiplier.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
`ifdef ALU_SEQ_MUL_EN
            prod_q      <= '0;
            mcand_q     <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && !is_mul) begin
                        result_q    <= res_c;
                        flags_q     <= flags_c;
                        out_valid_q <= 1'b1;
                    end
`ifdef ALU_SEQ_MUL_EN
                    else if (accept) begin
                        state_q     <= ST_BUSY;
                        prod_q      <= prod_first;
                        mcand_q     <= bus.a_i;
                        cnt_q       <= CntW'(1);
                        out_valid_q <= 1'b0;
                    end
`endif
                    else if (bus.out_ready_i) begin
                        out_valid_q <= 1'b0;
                    end
                end
                ST_BUSY: begin
`ifdef ALU_SEQ_MUL_EN
                    if (out_valid_q && bus.out_ready_i) begin
                        out_valid_q <= 1'b0;
                    end
                    prod_q <= prod_next;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(Width - 1)) begin
                        state_q     <= ST_IDLE;
                        cnt_q       <= '0;
                        result_q    <= prod_next[Width-1:0];
                        flags_q     <= {prod_next[Msb], (prod_next[Width-1:0] == '0),
                                        |prod_next[2*Width-1:Width], 1'b0};
                        out_valid_q <= 1'b1;
                    end
`else
                    state_q <= ST_IDLE;
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
